// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S/TDM transmitter.
package i2s_pkg;

  typedef enum logic {
    I2S_PHILIPS = 1'b0,
    I2S_LJ      = 1'b1
  } i2s_mode_e;

  function automatic int frame_bits(input int channels, input int slot_w);
    return channels * slot_w;
  endfunction

endpackage

// File: rtl/i2s_tdm_transmitter_sclk_gen.sv
// Bit-clock divider: sclk is mclk/MCLK_DIV at 50% duty; fall_tick marks the last mclk cycle of each sclk high phase.
// No handshake; free-running from reset release, first fall_tick in cycle MCLK_DIV-1.
module i2s_sclk_gen #(
  parameter int MCLK_DIV = 4
) (
  input  logic mclk,
  input  logic rst,
  output logic sclk,
  output logic fall_tick
);
  localparam int CW = $clog2(MCLK_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(MCLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(MCLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == FALL_AT) ? '0 : div_cnt_q + CW'(1);
    sclk_d    = sclk_q;
    if (div_cnt_q == RISE_AT) begin
      sclk_d = 1'b1;
    end else if (div_cnt_q == FALL_AT) begin
      sclk_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk      = sclk_q;
  assign fall_tick = (div_cnt_q == FALL_AT);

endmodule

// File: rtl/i2s_tdm_transmitter.sv
// Multi-channel I2S/left-justified serialiser with a one-frame holding register; outputs update one mclk after each fall tick.
// s_ready is low while a frame waits in hold; an empty hold at a frame boundary sends zeros and pulses underrun.
module i2s_tdm_transmitter
  import i2s_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int MCLK_DIV = 4
) (
  input  logic                       mclk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [CHANNELS*DATA_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       sclk,
  output logic                       lrclk,
  output logic                       sdout,
  output logic                       underrun
);
  localparam int FRAME_BITS = frame_bits(CHANNELS, SLOT_W);
  localparam int BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] LAST_BIT    = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] RIGHT_START = BW'((CHANNELS / 2) * SLOT_W);

  if (DATA_W < 8 || DATA_W > 32) begin : g_bad_data_w
    $error("DATA_W must be within 8..32");
  end
  if (SLOT_W < DATA_W) begin : g_bad_slot_w
    $error("SLOT_W must be at least DATA_W");
  end
  if (CHANNELS < 2 || CHANNELS > 8 || (CHANNELS % 2) != 0) begin : g_bad_channels
    $error("CHANNELS must be even and within 2..8");
  end
  if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_mclk_div
    $error("MCLK_DIV must be even and at least 2");
  end

  logic fall_tick;

  i2s_sclk_gen #(
    .MCLK_DIV(MCLK_DIV)
  ) u_sclk_gen (
    .mclk     (mclk),
    .rst      (rst),
    .sclk     (sclk),
    .fall_tick(fall_tick)
  );

  logic [CHANNELS*DATA_W-1:0] hold_q, hold_d;
  logic                       hold_v_q, hold_v_d;
  logic [FRAME_BITS-1:0]      shift_q, shift_d;
  logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
  i2s_mode_e                  mode_q, mode_d;
  logic                       dly_q, dly_d;
  logic                       lrclk_q, lrclk_d;
  logic                       sdout_q, sdout_d;
  logic                       underrun_q, underrun_d;

  logic [FRAME_BITS-1:0]      frame_fmt;
  logic                       boundary;
  logic                       lj_bit;

  // Slot 0 sits at the MSB end so the frame shifts out left to right; slot padding stays zero.
  always_comb begin
    frame_fmt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      frame_fmt[FRAME_BITS-1-k*SLOT_W -: DATA_W] = hold_q[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    mode_d     = mode_q;
    dly_d      = dly_q;
    lrclk_d    = lrclk_q;
    sdout_d    = sdout_q;
    underrun_d = 1'b0;
    boundary   = 1'b0;
    lj_bit     = 1'b0;

    if (s_valid && !hold_v_q) begin
      hold_d   = s_data;
      hold_v_d = 1'b1;
    end

    if (fall_tick) begin
      boundary  = (bit_cnt_q == LAST_BIT);
      bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);
      if (boundary) begin
        if (hold_v_q) begin
          shift_d  = frame_fmt;
          hold_v_d = 1'b0;
          mode_d   = i2s_mode_e'(mode);
        end else begin
          shift_d    = '0;
          underrun_d = 1'b1;
        end
      end
      lj_bit  = shift_d[FRAME_BITS-1];
      shift_d = {shift_d[FRAME_BITS-2:0], 1'b0};
      // Philips format emits the bit from one sclk earlier, so frame bit 0 carries the previous frame's last bit.
      dly_d   = lj_bit;
      sdout_d = (mode_d == I2S_LJ) ? lj_bit : dly_q;
      lrclk_d = (bit_cnt_d >= RIGHT_START);
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= LAST_BIT;
      mode_q     <= I2S_PHILIPS;
      dly_q      <= 1'b0;
      lrclk_q    <= 1'b0;
      sdout_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      mode_q     <= mode_d;
      dly_q      <= dly_d;
      lrclk_q    <= lrclk_d;
      sdout_q    <= sdout_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_ready  = !hold_v_q;
  assign lrclk    = lrclk_q;
  assign sdout    = sdout_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tdm_transmitter.sv
// Directed bench: stereo default instance plus a 4-channel/24-bit-slot/div-8 instance.
module tb_i2s_tdm_transmitter;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        rst, mode, s_valid, s_ready, sclk, lrclk, sdout, underrun;
  logic [47:0] s_data;
  logic        rst4, mode4, s_valid4, s_ready4, sclk4, lrclk4, sdout4, underrun4;
  logic [95:0] s_data4;

  i2s_tdm_transmitter u_dut (
    .mclk(mclk), .rst(rst), .mode(mode), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .sclk(sclk), .lrclk(lrclk), .sdout(sdout), .underrun(underrun)
  );

  i2s_tdm_transmitter #(.DATA_W(24), .SLOT_W(24), .CHANNELS(4), .MCLK_DIV(8)) u_dut4 (
    .mclk(mclk), .rst(rst4), .mode(mode4), .s_data(s_data4), .s_valid(s_valid4),
    .s_ready(s_ready4), .sclk(sclk4), .lrclk(lrclk4), .sdout(sdout4), .underrun(underrun4)
  );

  typedef struct {
    logic        md;
    logic [23:0] ch0;
    logic [23:0] ch1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc;
  bit   use4;
  logic cap_sd[512];
  logic cap_lr[512];
  int   ur_q[$];
  int   lr_rise_q[$];
  int   rdy_hi, rdy_rise, sclk_err, sd_ones;
  logic lr_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] capword(input bit lr, input int start, input int w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < w; b++) r = {r[30:0], lr ? cap_lr[start+b] : cap_sd[start+b]};
    return r;
  endfunction

  task automatic sample();
    int   div, off, j;
    logic sc, ur, rd, sd, lr;
    div = use4 ? 8 : 4;
    off = use4 ? 12 : 6;
    sc  = use4 ? sclk4 : sclk;
    ur  = use4 ? underrun4 : underrun;
    rd  = use4 ? s_ready4 : s_ready;
    sd  = use4 ? sdout4 : sdout;
    lr  = use4 ? lrclk4 : lrclk;
    if (sc !== ((cyc % div) >= div / 2)) sclk_err++;
    if (ur === 1'b1) ur_q.push_back(cyc);
    if (rd === 1'b1) rdy_hi++;
    if (rd === 1'b1 && cyc > 0 && rdy_rise < 0) rdy_rise = cyc;
    if (sd !== 1'b0) sd_ones++;
    if (lr === 1'b1 && lr_prev === 1'b0) lr_rise_q.push_back(cyc);
    lr_prev = lr;
    if (cyc >= off && (cyc - off) % div == 0) begin
      j = (cyc - off) / div;
      if (j < 512) begin
        cap_sd[j] = sd;
        cap_lr[j] = lr;
      end
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic do_reset(input bit four);
    rst      = 1'b1;
    rst4     = 1'b1;
    s_valid  = 1'b0;
    s_valid4 = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    use4 = four;
    if (four) rst4 = 1'b0;
    else      rst  = 1'b0;
    cyc = 0;
    ur_q.delete();
    lr_rise_q.delete();
    rdy_hi = 0; rdy_rise = -1; sclk_err = 0; sd_ones = 0; lr_prev = 1'b0;
    for (int i = 0; i < 512; i++) begin
      cap_sd[i] = 1'bx;
      cap_lr[i] = 1'bx;
    end
    sample();
  endtask

  initial begin
    vec_t        vecs[4];
    int          mism;
    logic [23:0] ch4[4];

    rst = 1'b1; rst4 = 1'b1; mode = 1'b0; mode4 = 1'b0;
    s_valid = 1'b0; s_valid4 = 1'b0; s_data = '0; s_data4 = '0;
    use4 = 1'b0; cyc = 0;

    vecs[0] = '{md: 1'b1, ch0: 24'h00C491, ch1: 24'h8A01D0, exp0: 32'h00C49100, exp1: 32'h8A01D000};
    vecs[1] = '{md: 1'b0, ch0: 24'h00C491, ch1: 24'h8A01D0, exp0: 32'h00C49100, exp1: 32'h8A01D000};
    vecs[2] = '{md: 1'b1, ch0: 24'hFFFFFF, ch1: 24'h000001, exp0: 32'hFFFFFF00, exp1: 32'h00000100};
    vecs[3] = '{md: 1'b0, ch0: 24'h800000, ch1: 24'h7FFFFF, exp0: 32'h80000000, exp1: 32'h7FFFFF00};

    // Reset values while held in reset.
    repeat (3) @(posedge mclk);
    #1;
    check("rst sclk", sclk, 0);
    check("rst lrclk", lrclk, 0);
    check("rst sdout", sdout, 0);
    check("rst underrun", underrun, 0);
    check("rst s_ready", s_ready, 1);

    // Idle: no data ever offered.
    do_reset(0);
    while (cyc < 520) tick();
    check("idle sclk period/duty errors", sclk_err, 0);
    check("idle sdout nonzero cycles", sd_ones, 0);
    check("idle lrclk rise count", lr_rise_q.size(), 2);
    check("idle lrclk first rise", lr_rise_q.size() > 0 ? lr_rise_q[0] : -1, 132);
    check("idle lrclk second rise", lr_rise_q.size() > 1 ? lr_rise_q[1] : -1, 388);
    check("idle underrun count", ur_q.size(), 3);
    check("idle underrun #0 cycle", ur_q.size() > 0 ? ur_q[0] : -1, 4);
    check("idle underrun #1 cycle", ur_q.size() > 1 ? ur_q[1] : -1, 260);
    check("idle underrun #2 cycle", ur_q.size() > 2 ? ur_q[2] : -1, 516);

    // Single frame loaded before the first boundary, LJ and Philips.
    for (int i = 0; i < 4; i++) begin
      int st;
      do_reset(0);
      mode    = vecs[i].md;
      s_data  = {vecs[i].ch1, vecs[i].ch0};
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      check($sformatf("v%0d s_ready drop", i), s_ready, 0);
      while (cyc < 300) tick();
      st = vecs[i].md ? 0 : 1;
      check($sformatf("v%0d slot0 bits", i), capword(0, st, 32), vecs[i].exp0);
      check($sformatf("v%0d slot1 bits", i), capword(0, st + 32, 32), vecs[i].exp1);
      check($sformatf("v%0d lrclk slot0", i), capword(1, 0, 32), 32'h00000000);
      check($sformatf("v%0d lrclk slot1", i), capword(1, 32, 32), 32'hFFFFFFFF);
      check($sformatf("v%0d underrun count", i), ur_q.size(), 1);
      check($sformatf("v%0d underrun cycle", i), ur_q.size() > 0 ? ur_q[0] : -1, 260);
      check($sformatf("v%0d s_ready rise cycle", i), rdy_rise, 4);
      if (!vecs[i].md) check($sformatf("v%0d i2s frame bit0", i), cap_sd[0], 0);
    end

    // Back-to-back frames with s_valid held high.
    do_reset(0);
    mode    = 1'b1;
    s_data  = {24'h000000, 24'hFFFFFF};
    s_valid = 1'b1;
    while (cyc < 771) tick();
    s_valid = 1'b0;
    mism = 0;
    for (int j = 0; j < 192; j++) begin
      if (cap_sd[j] !== logic'(((j / 32) % 2 == 0) && (j % 32 < 24))) mism++;
    end
    check("b2b stream mismatching bits", mism, 0);
    check("b2b underrun count", ur_q.size(), 0);
    check("b2b s_ready high cycles", rdy_hi, 4);

    // Frame offered exactly in the first boundary cycle, then reset mid-slot.
    do_reset(0);
    mode = 1'b1;
    while (cyc < 3) tick();
    s_data  = {24'hA5A5A5, 24'hFFFFFF};
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check("race s_ready after accept", s_ready, 0);
    check("race underrun at boundary", ur_q.size() > 0 ? ur_q[0] : -1, 4);
    while (cyc < 300) tick();
    s_data  = {24'h123456, 24'h654321};
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    while (cyc < 390) tick();
    check("race frame0 slot0 zeros", capword(0, 0, 32), 0);
    check("race frame0 slot1 zeros", capword(0, 32, 32), 0);
    check("race frame1 slot0", capword(0, 64, 32), 32'hFFFFFF00);
    check("race underrun count", ur_q.size(), 1);
    check("race pre-reset sdout", sdout, 1);
    check("race pre-reset lrclk", lrclk, 1);
    check("race pre-reset sclk", sclk, 1);
    check("race pre-reset s_ready", s_ready, 0);
    rst = 1'b1;
    #1;
    check("midrst sclk", sclk, 0);
    check("midrst lrclk", lrclk, 0);
    check("midrst sdout", sdout, 0);
    check("midrst underrun", underrun, 0);
    check("midrst s_ready", s_ready, 1);
    do_reset(0);
    while (cyc < 270) tick();
    check("post-rst hold discarded: underrun count", ur_q.size(), 2);
    check("post-rst first underrun", ur_q.size() > 0 ? ur_q[0] : -1, 4);
    check("post-rst sdout nonzero cycles", sd_ones, 0);

    // Four-channel TDM instance.
    ch4[0] = 24'hC00001; ch4[1] = 24'h0F0F0F; ch4[2] = 24'h800000; ch4[3] = 24'h00FFFF;
    do_reset(1);
    mode4    = 1'b1;
    s_data4  = {ch4[3], ch4[2], ch4[1], ch4[0]};
    s_valid4 = 1'b1;
    tick();
    s_valid4 = 1'b0;
    while (cyc < 790) tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tdm4 slot%0d data", k), capword(0, 24 * k, 24), {8'h00, ch4[k]});
      check($sformatf("tdm4 slot%0d lrclk", k), capword(1, 24 * k, 24), (k >= 2) ? 32'h00FFFFFF : 32'h0);
    end
    check("tdm4 sclk period/duty errors", sclk_err, 0);
    check("tdm4 underrun count", ur_q.size(), 1);
    check("tdm4 underrun cycle", ur_q.size() > 0 ? ur_q[0] : -1, 776);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_tdm_transmitter.md
# i2s_tdm_transmitter

Parametrised successor of the stereo I2S transmitter. It runs on a single `mclk` domain and generates `sclk` and `lrclk` internally from a programmable divider. It accepts whole sample frames of `CHANNELS` channels through a valid/ready handshake and serialises them MSB-first in Philips-I2S or left-justified format, flagging underruns. It sits between the effects pipeline output and the codec DAC pins.

## Interface
- `DATA_W`, 24: sample width; 8..32.
- `SLOT_W`, 32: bits per channel slot; `SLOT_W >= DATA_W`.
- `CHANNELS`, 2: channels per frame; even, 2..8.
- `MCLK_DIV`, 4: `mclk` cycles per `sclk` period; even, ≥2.
- `mclk`  in  1  system/master clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  1  0 = Philips I2S (1-bit delay), 1 = left-justified; sampled at frame boundary only.
- `s_data`  in  `CHANNELS*DATA_W`  frame; channel 0 in the LSBs.
- `s_valid`  in  1  frame valid.
- `s_ready`  out  1  holding register empty.
- `sclk`  out  1  bit clock.
- `lrclk`  out  1  frame/word select.
- `sdout`  out  1  serial data.
- `underrun`  out  1  one-`mclk` pulse when a frame boundary finds no data.

## Operation
- `FRAME_BITS = CHANNELS*SLOT_W`.
- One-entry holding register `hold`, with flag `hold_v`.
- `s_ready = !hold_v`. The transfer `s_valid && s_ready` loads `hold` and sets `hold_v`.
- Divider `div_cnt` counts 0..`MCLK_DIV-1` and wraps. `sclk` is set after the cycle with `div_cnt == MCLK_DIV/2-1`. It is cleared after the cycle with `div_cnt == MCLK_DIV-1`; that cycle is the *fall tick*.
- On each fall tick, `bit_cnt` advances modulo `FRAME_BITS`, and `lrclk` and `sdout` update. The downstream receiver samples on `sclk` rising edges.
- Frame boundary is a fall tick where `bit_cnt` wraps to 0. At the boundary:
  - If `hold_v`: copy `hold` to the shift register, clear `hold_v`, latch `mode`.
  - Else: load zeros into the shift register and pulse `underrun`.
- Slot `k` (`bit_cnt / SLOT_W`) carries channel `k`. The first `DATA_W` bits are MSB-first, and the remaining `SLOT_W-DATA_W` bits are 0.
- `lrclk` is 0 for slots `0..CHANNELS/2-1` and 1 for the rest. It is not delayed by mode.
- Left-justified mode: `sdout` is the stream bit for the current `bit_cnt`.
- I2S mode: `sdout` is the LJ stream bit from the previous fall tick. Frame bit 0 therefore carries the last bit of the previous frame.
- No bypass. A frame accepted in the same cycle as a boundary with `hold_v == 0` does not transmit in that frame: `underrun` pulses, and the new frame goes out at the next boundary.

## Timing
- Reset values:
  - `sclk = 0`, `lrclk = 0`, `sdout = 0`, `underrun = 0`.
  - `s_ready = 1`, `hold_v = 0`.
  - `div_cnt = 0`, `bit_cnt = FRAME_BITS-1`, shift register = 0, I2S delay bit = 0.
- First fall tick occurs in cycle `MCLK_DIV-1` after reset release. It is the first frame boundary.
- `sclk` duty is exactly 50%. Its period is `MCLK_DIV` `mclk` cycles.
- Frame period is `FRAME_BITS*MCLK_DIV` `mclk` cycles.
- `underrun` asserts in the cycle after the boundary fall tick, for one cycle.
- `s_ready` drops the cycle after a transfer. It rises the cycle after the boundary that consumes `hold`.
- `rst` asserted mid-frame returns everything to reset values immediately and discards `hold` and the shift register.
- A change on `mode` mid-frame has no effect until the next boundary.

## Structure
- Package `i2s_pkg` holds:
  - enum `i2s_mode_e` (`I2S_PHILIPS = 1'b0`, `I2S_LJ = 1'b1`)
  - function `frame_bits(channels, slot_w)`.
- Sub-module `i2s_sclk_gen` (param `MCLK_DIV`) holds `div_cnt` and outputs `sclk` and the `fall_tick` strobe.
- The top level holds the holding register, shift/bit counter, mode latch and I2S delay flop.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
All scenarios use defaults (`DATA_W=24`, `SLOT_W=32`, `CHANNELS=2`, `MCLK_DIV=4`) unless stated.
- Reset, then no `s_valid` → `sclk` period 4 cycles and `lrclk` period 256 cycles. `sdout` stays 0. `underrun` pulses once per frame, first one in cycle 4.
- LJ mode, frame {ch1=0x8A01D0, ch0=0x00C491} loaded before the first boundary:
  - Slot 0 bits are 0x00C491 MSB-first, then 8 zeros, with `lrclk=0`.
  - Slot 1 is 0x8A01D0, with `lrclk=1`.
  - No `underrun`.
- I2S mode, same data → identical bit stream delayed one `sclk`. The first `sdout` after the `lrclk` fall is the previous frame's last bit (0).
- Back-to-back: `s_valid` held high with 0xFFFFFF/0x000000 frames → `s_ready` pulses once per 256 cycles, no `underrun`, and the pattern alternates per slot.
- Boundary race: assert `s_valid` exactly in a boundary fall-tick cycle with `hold_v=0` → `underrun` pulses and the data appears in the following frame. Then `rst` mid-slot → all outputs return to 0 and `s_ready` returns to 1 immediately.
- `CHANNELS=4`, `SLOT_W=24`, `MCLK_DIV=8` → frame is 96 bits / 768 cycles, `lrclk` is high for slots 2–3, and channels appear in order 0..3.
